// File: rtl/vproc_mem_copy_master.sv
// rtl/vproc_mem_copy_master.sv - word copy engine on the vproc main memory port
// Reads are credit-limited so buffered read data can never overflow the data FIFO.
module vproc_mem_copy_master #(
   parameter int MAX_OUTST = 4,
   parameter int LEN_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             mem_req_o,
   output logic [31:0]      mem_addr_o,
   output logic             mem_we_o,
   output logic [3:0]       mem_be_o,
   output logic [31:0]      mem_wdata_o,
   input  logic             mem_rvalid_i,
   input  logic             mem_err_i,
   input  logic [31:0]      mem_rdata_i
);
   localparam int PW = $clog2(MAX_OUTST);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);
   localparam logic [CW:0]   MAX_SUM = (CW+1)'(MAX_OUTST);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [31:0]          src_ptr, dst_ptr;
   logic [LEN_W-1:0]     rd_left, wr_left;
   logic [MAX_OUTST-1:0] tag_mem;
   logic [PW-1:0]        tag_wp, tag_rp;
   logic [CW-1:0]        tag_cnt;
   logic [31:0]          dat_mem [MAX_OUTST];
   logic [PW-1:0]        dat_wp, dat_rp;
   logic [CW-1:0]        dat_cnt;
   logic [CW-1:0]        rd_infl;

   logic resp, resp_rd, resp_err, abort, dat_push, credit;
   logic issue_rd, issue_wr, issue;

   // A response with no tag outstanding is stale (e.g. issued before a reset).
   assign resp     = mem_rvalid_i && (tag_cnt != '0);
   assign resp_rd  = resp && !tag_mem[tag_rp];
   assign resp_err = resp && mem_err_i;
   assign abort    = (state == RUN) && resp_err;
   assign dat_push = resp_rd && (state == RUN) && !mem_err_i;
   assign credit   = (({1'b0, rd_infl} + {1'b0, dat_cnt}) < MAX_SUM) && (tag_cnt < MAX_CNT);
   assign issue    = issue_rd || issue_wr;
   assign mem_be_o = 4'hF;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = (len_i != '0) ? RUN : DONE;
         RUN:     if (abort || (wr_left == '0)) state_nxt = DRAIN;
         DRAIN:   if (tag_cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Draining buffered data always takes priority over fetching more.
   always_comb begin
      busy_o   = (state == RUN) || (state == DRAIN);
      done_o   = (state == DONE);
      issue_wr = (state == RUN) && !resp_err && (dat_cnt != '0);
      issue_rd = (state == RUN) && !resp_err && (dat_cnt == '0) && (rd_left != '0) && credit;
   end

   always_ff @(posedge clk_i) begin
      if (dat_push) dat_mem[dat_wp] <= mem_rdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_ptr     <= '0;
         dst_ptr     <= '0;
         rd_left     <= '0;
         wr_left     <= '0;
         tag_mem     <= '0;
         tag_wp      <= '0;
         tag_rp      <= '0;
         tag_cnt     <= '0;
         dat_wp      <= '0;
         dat_rp      <= '0;
         dat_cnt     <= '0;
         rd_infl     <= '0;
         err_o       <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         if (state == IDLE && start_i) begin
            src_ptr <= src_addr_i & ~32'h3;
            dst_ptr <= dst_addr_i & ~32'h3;
            rd_left <= len_i;
            wr_left <= len_i;
         end
         if (issue_rd) begin
            src_ptr <= src_ptr + 32'd4;
            rd_left <= rd_left - LEN_W'(1);
         end
         if (issue_wr) begin
            dst_ptr <= dst_ptr + 32'd4;
            wr_left <= wr_left - LEN_W'(1);
         end

         if (issue) begin
            tag_mem[tag_wp] <= issue_wr;
            tag_wp          <= tag_wp + PW'(1);
         end
         if (resp) tag_rp <= tag_rp + PW'(1);
         case ({issue, resp})
            2'b10:   tag_cnt <= tag_cnt + CW'(1);
            2'b01:   tag_cnt <= tag_cnt - CW'(1);
            default: tag_cnt <= tag_cnt;
         endcase
         case ({issue_rd, resp_rd})
            2'b10:   rd_infl <= rd_infl + CW'(1);
            2'b01:   rd_infl <= rd_infl - CW'(1);
            default: rd_infl <= rd_infl;
         endcase

         if (abort) begin
            dat_wp  <= '0;
            dat_rp  <= '0;
            dat_cnt <= '0;
         end else begin
            if (dat_push) dat_wp <= dat_wp + PW'(1);
            if (issue_wr) dat_rp <= dat_rp + PW'(1);
            case ({dat_push, issue_wr})
               2'b10:   dat_cnt <= dat_cnt + CW'(1);
               2'b01:   dat_cnt <= dat_cnt - CW'(1);
               default: dat_cnt <= dat_cnt;
            endcase
         end

         if (state == IDLE && start_i) err_o <= 1'b0;
         else if (resp_err)            err_o <= 1'b1;

         if (issue_wr) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= dst_ptr;
            mem_wdata_o <= dat_mem[dat_rp];
         end else if (issue_rd) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= src_ptr;
            mem_wdata_o <= '0;
         end else begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
         end
      end
   end
endmodule

// File: tb/tb_vproc_mem_copy_master.sv
// tb/tb_vproc_mem_copy_master.sv - scoreboard bench with a fixed-latency memory responder
module tb_vproc_mem_copy_master;
   localparam int MAX_OUTST = 4;
   localparam int LEN_W     = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [31:0]      src = '0, dst = '0;
   logic [LEN_W-1:0] len = '0;
   logic             busy, done, err, req, we;
   logic [31:0]      addr, wdata;
   logic [3:0]       be;
   logic             rvalid = 1'b0, rerr = 1'b0;
   logic [31:0]      rdata = '0;

   vproc_mem_copy_master #(.MAX_OUTST(MAX_OUTST), .LEN_W(LEN_W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .src_addr_i(src), .dst_addr_i(dst),
      .len_i(len), .busy_o(busy), .done_o(done), .err_o(err), .mem_req_o(req),
      .mem_addr_o(addr), .mem_we_o(we), .mem_be_o(be), .mem_wdata_o(wdata),
      .mem_rvalid_i(rvalid), .mem_err_i(rerr), .mem_rdata_i(rdata)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Memory contents are a hash of the word address, so expected copy data is plain arithmetic.
   logic [31:0] seed = 32'h1234_5678;
   function automatic logic [31:0] pattern(input logic [31:0] a);
      return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ seed;
   endfunction

   logic [31:0] exp_rd[$];
   logic [63:0] exp_wr[$];

   typedef struct {int due; logic rd; logic [31:0] data;} resp_t;
   resp_t pend[$];
   int lat = 1, err_read_n = -1, rd_resp_idx = 0, err_cyc = -1;
   int rvalid_cnt = 0, max_infl = 0, infl = 0;

   resp_t r;
   always @(negedge clk) begin
      if (req === 1'b1) begin
         r.due  = cyc + lat;
         r.rd   = !we;
         r.data = we ? 32'h0 : pattern(addr);
         pend.push_back(r);
      end
      infl = pend.size();
      if (infl > max_infl) max_infl = infl;
      rvalid = 1'b0;
      rerr   = 1'b0;
      rdata  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         r      = pend.pop_front();
         rvalid = 1'b1;
         rdata  = r.data;
         rvalid_cnt++;
         if (r.rd) begin
            rd_resp_idx++;
            if (rd_resp_idx == err_read_n) begin
               rerr    = 1'b1;
               err_cyc = cyc;
            end
         end
      end
   end

   int done_cnt = 0, done_cyc = -1, req_cnt = 0, last_req_cyc = -1;
   logic [63:0] w;
   always @(negedge clk) begin
      if (!rst) begin
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (req === 1'b1) begin
            req_cnt++;
            last_req_cyc = cyc;
            chk("mem_be", {28'h0, be}, 32'hF);
            if (we) begin
               if (exp_wr.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_write actual=%h required=none", addr);
               end else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", addr, w[63:32]);
                  chk("wr_data", wdata, w[31:0]);
               end
            end else begin
               if (exp_rd.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_read actual=%h required=none", addr);
               end else begin
                  chk("rd_addr", addr, exp_rd.pop_front());
                  chk("rd_wdata", wdata, 32'h0);
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   int start_cyc = 0;
   task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      logic [31:0] sa, da;
      sa = s & ~32'h3;
      da = d & ~32'h3;
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(sa + 32'(4 * i));
         exp_wr.push_back({da + 32'(4 * i), pattern(sa + 32'(4 * i))});
      end
      done_cnt = 0; rvalid_cnt = 0; max_infl = 0; rd_resp_idx = 0;
      err_cyc = -1; req_cnt = 0; last_req_cyc = -1; done_cyc = -1;
      src = s; dst = d; len = LEN_W'(n); start = 1'b1;
      start_cyc = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      int k;
      k = 0;
      while (done_cnt == 0 && k < bound) begin
         step();
         k++;
      end
      if (done_cnt == 0) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no_done required=done_within_%0d", name, bound);
      end
   endtask

   task automatic check_copy(input string name, input int n);
      repeat (4) step();
      chk({name, "_done_once"}, done_cnt, 1);
      chk({name, "_err"}, err, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_reads_left"}, exp_rd.size(), 0);
      chk({name, "_writes_left"}, exp_wr.size(), 0);
      chk({name, "_rvalids"}, rvalid_cnt, 2 * n);
      chk({name, "_inflight_le_max"}, (max_infl <= MAX_OUTST), 1);
   endtask

   initial begin
      repeat (3) step();
      rst = 1'b0;
      req_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_err", err, 0);
         chk("idle_req", req, 0);
         chk("idle_we", we, 0);
         chk("idle_addr", addr, 0);
         chk("idle_wdata", wdata, 0);
         chk("idle_be", {28'h0, be}, 32'hF);
      end
      chk("idle_req_count", req_cnt, 0);

      seed = $urandom;
      lat = 1;
      start_copy(32'h100, 32'h800, 8);
      wait_done("lat1", 400);
      check_copy("lat1", 8);

      lat = 6;
      start_copy(32'h100, 32'h800, 8);
      wait_done("lat6", 600);
      check_copy("lat6", 8);

      lat = 2;
      start_copy(32'h40, 32'h80, 0);
      repeat (4) step();
      chk("len0_done_once", done_cnt, 1);
      chk("len0_latency_ok", ((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 1);
      chk("len0_no_requests", req_cnt, 0);

      lat = 3;
      err_read_n = 3;
      start_copy(32'h2000, 32'h3000, 8);
      wait_done("abort", 400);
      chk("abort_err_set", err, 1);
      chk("abort_error_seen", (err_cyc >= 0), 1);
      chk("abort_no_req_after_err", (last_req_cyc <= err_cyc), 1);
      chk("abort_drained", pend.size(), 0);
      repeat (4) step();
      chk("abort_done_once", done_cnt, 1);
      chk("abort_err_sticky", err, 1);
      exp_rd.delete();
      exp_wr.delete();
      err_read_n = -1;

      lat = 6;
      start_copy(32'h5000, 32'h6000, 8);
      begin
         int k;
         k = 0;
         while (infl != 3 && k < 50) begin
            step();
            k++;
         end
         chk("reset_reached_3_inflight", infl, 3);
      end
      rst = 1'b1;
      step();
      chk("reset_busy", busy, 0);
      chk("reset_req", req, 0);
      chk("reset_err", err, 0);
      rst = 1'b0;
      exp_rd.delete();
      exp_wr.delete();
      begin
         int k;
         k = 0;
         while (pend.size() != 0 && k < 50) begin
            step();
            k++;
         end
      end
      repeat (5) step();
      chk("stale_ignored_busy", busy, 0);
      chk("stale_ignored_err", err, 0);

      lat = 1;
      start_copy(32'h0, 32'hFFFF_FFF8, 4);
      wait_done("wrap", 200);
      check_copy("wrap", 4);

      for (int t = 0; t < 4; t++) begin
         int n;
         lat = $urandom_range(1, 5);
         n = $urandom_range(1, 12);
         start_copy($urandom, $urandom, n);
         wait_done("rand", 800);
         check_copy("rand", n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
